// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped interval timer with sticky IRQ and free-running
// SysTick, sitting on the data side of the multi-cycle MIPS core.
// Optional build macro TIMER_PRESCALE_EN: divide the TL tick by PRESCALE.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned PRESCALE  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] Read_data,
  output logic        Sel,
  output logic        IRQ
);

  localparam logic [2:0]  OFF_TH      = 3'd0;
  localparam logic [2:0]  OFF_TL      = 3'd1;
  localparam logic [2:0]  OFF_TCON    = 3'd2;
  localparam logic [2:0]  OFF_SYSTICK = 3'd5;
  localparam logic [31:0] ALL_ONES    = '1;

  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;
  logic [31:0] systick;
  logic [2:0]  offset;
  logic        wr_en;
  logic        wr_th;
  logic        wr_tl;
  logic        wr_tcon;
  logic        tick;
  logic        overflow;
  logic        hw_set;

  assign Sel     = (Address[31:5] == BASE_ADDR[31:5]);
  assign offset  = Address[4:2];
  assign wr_en   = Sel && MemWrite;
  assign wr_th   = wr_en && (offset == OFF_TH);
  assign wr_tl   = wr_en && (offset == OFF_TL);
  assign wr_tcon = wr_en && (offset == OFF_TCON);
  assign IRQ     = tcon[2];

`ifdef TIMER_PRESCALE_EN
  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);
  logic [15:0] pre_cnt;
  logic        unused_bits;
  assign unused_bits = ^Address[1:0];

  // Tick only on the last prescaler count while enabled
  assign tick = tcon[0] && (pre_cnt == PRE_LAST);

  // Prescaler: counts enabled cycles, cleared by disabling EN or writing TL
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pre_cnt <= '0;
    else if ((wr_tcon && !Write_data[0]) || wr_tl)
      pre_cnt <= '0;
    else if (tcon[0])
      pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 16'd1;
  end
`else
  logic unused_bits;
  assign unused_bits = ^{Address[1:0], 32'(PRESCALE)};

  // Without the prescaler every enabled cycle is a tick
  assign tick = tcon[0];
`endif

  assign overflow = tick && (tl == ALL_ONES);
  // A TL write on the same edge discards the tick, so it also discards the flag
  assign hw_set   = overflow && tcon[1] && !wr_tl;

  // Combinational read mux; zero when no load targets the window
  always_comb begin
    Read_data = '0;
    if (Sel && MemRead) begin
      case (offset)
        OFF_TH:      Read_data = th;
        OFF_TL:      Read_data = tl;
        OFF_TCON:    Read_data = {29'd0, tcon};
        OFF_SYSTICK: Read_data = systick;
        default:     Read_data = '0;
      endcase
    end
  end

  // Reload register: software-written only; overflow reloads use the old value
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      th <= '0;
    else if (wr_th)
      th <= Write_data;
  end

  // Counter: CPU write beats tick; overflow reloads from TH
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      tl <= '0;
    else if (wr_tl)
      tl <= Write_data;
    else if (overflow)
      tl <= th;
    else if (tick)
      tl <= tl + 32'd1;
  end

  // Control/status: hardware ST set wins over a software clear on the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      tcon <= '0;
    else if (wr_tcon)
      tcon <= {Write_data[2] | hw_set, Write_data[1:0]};
    else if (hw_set)
      tcon[2] <= 1'b1;
  end

  // Free-running cycle counter, wraps silently
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      systick <= '0;
    else
      systick <= systick + 32'd1;
  end

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: randomized and directed stimulus against a register-level
// reference model of the timer peripheral.
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int unsigned PRE  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Read_data;
  logic        Sel;
  logic        IRQ;

  mmio_timer #(.BASE_ADDR(BASE), .PRESCALE(PRE)) dut (
    .clk(clk), .reset(reset), .Address(Address), .Write_data(Write_data),
    .MemRead(MemRead), .MemWrite(MemWrite), .Read_data(Read_data),
    .Sel(Sel), .IRQ(IRQ)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // reference model state
  logic [31:0] m_th, m_tl, m_sys;
  logic        m_en, m_ie, m_st;
  int unsigned m_pre;
  logic [31:0] last_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_th = 0; m_tl = 0; m_sys = 0; m_en = 0; m_ie = 0; m_st = 0; m_pre = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] off);
    case (off)
      3'd0:    return m_th;
      3'd1:    return m_tl;
      3'd2:    return {29'd0, m_st, m_ie, m_en};
      3'd5:    return m_sys;
      default: return 32'd0;
    endcase
  endfunction

  // Advance the model by one clock edge given the bus inputs of that cycle
  task automatic model_edge(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    logic        tick, hw;
    logic [31:0] ntl;
    logic        nen, nie, nst;
    int unsigned npre;
    tick = m_en;
`ifdef TIMER_PRESCALE_EN
    tick = m_en && (m_pre == PRE - 1);
`endif
    npre = m_en ? ((m_pre == PRE - 1) ? 0 : m_pre + 1) : m_pre;
    hw  = 0;
    ntl = m_tl;
    if (tick) begin
      if (m_tl == 32'hFFFF_FFFF) begin
        ntl = m_th;
        hw  = m_ie;
      end else begin
        ntl = m_tl + 1;
      end
    end
    nen = m_en; nie = m_ie; nst = m_st | hw;
    if (wr && addr[31:5] == BASE[31:5]) begin
      case (addr[4:2])
        3'd0: m_th = data;
        3'd1: begin ntl = data; nst = m_st; npre = 0; end
        3'd2: begin
          nen = data[0]; nie = data[1]; nst = data[2] | hw;
          if (!data[0]) npre = 0;
        end
        default: ;
      endcase
    end
    m_tl = ntl; m_en = nen; m_ie = nie; m_st = nst; m_pre = npre;
    m_sys = m_sys + 1;
  endtask

  // One bus cycle: drive at negedge, check combinational outputs, then edge
  task automatic do_cycle(input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [31:0] data);
    logic sel_exp;
    @(negedge clk);
    MemWrite = wr; MemRead = rd; Address = addr; Write_data = data;
    #1;
    sel_exp = (addr[31:5] == BASE[31:5]);
    last_rd = Read_data;
    check("sel", {31'd0, Sel}, {31'd0, sel_exp});
    check("irq", {31'd0, IRQ}, {31'd0, m_st});
    check("rdata", Read_data, (rd && sel_exp) ? model_read(addr[4:2]) : 32'd0);
    @(posedge clk);
    model_edge(wr, addr, data);
  endtask

  task automatic wr_reg(input logic [4:0] off, input logic [31:0] data);
    do_cycle(1'b1, 1'b0, BASE + {27'd0, off}, data);
  endtask

  task automatic rd_reg(input logic [4:0] off);
    do_cycle(1'b0, 1'b1, BASE + {27'd0, off}, 32'd0);
  endtask

  task automatic idle();
    do_cycle(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    logic [31:0] a, d, s0;
    int unsigned kind;

    reset = 1'b1; MemRead = 0; MemWrite = 0; Address = 0; Write_data = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    rd_reg(5'h00); check("rst_th", last_rd, 32'd0);
    rd_reg(5'h04); check("rst_tl", last_rd, 32'd0);
    rd_reg(5'h08); check("rst_tcon", last_rd, 32'd0);
    do_cycle(1'b0, 1'b1, 32'h0000_0010, 32'd0);
    check("rst_sel_out", {31'd0, Sel}, 32'd0);

    // overflow with IE: reload from TH and IRQ set
    wr_reg(5'h00, 32'hFFFF_FFFC);
    wr_reg(5'h04, 32'hFFFF_FFFE);
    wr_reg(5'h08, 32'd3);
`ifndef TIMER_PRESCALE_EN
    rd_reg(5'h04); check("ovf_tl0", last_rd, 32'hFFFF_FFFE);
    rd_reg(5'h04); check("ovf_tl1", last_rd, 32'hFFFF_FFFF);
    rd_reg(5'h04); check("ovf_tl2", last_rd, 32'hFFFF_FFFC);
    check("ovf_irq", {31'd0, IRQ}, 32'd1);
    idle();
    check("irq_sticky", {31'd0, IRQ}, 32'd1);
    wr_reg(5'h08, 32'd3);
    idle();
    check("irq_clear", {31'd0, IRQ}, 32'd0);
`endif

    // overflow with IE=0: reload without IRQ
    wr_reg(5'h08, 32'd1);
    wr_reg(5'h04, 32'hFFFF_FFFF);
    repeat (PRE) idle();
    rd_reg(5'h04);
`ifndef TIMER_PRESCALE_EN
    check("noie_reload", last_rd, 32'hFFFF_FFFC + 32'(PRE - 1));
`endif
    check("noie_irq", {31'd0, IRQ}, 32'd0);
    rd_reg(5'h08); check("noie_tcon", last_rd, 32'd1);

    // TL write on overflow edge wins; ST clear on overflow edge loses
`ifndef TIMER_PRESCALE_EN
    wr_reg(5'h08, 32'd3);
    wr_reg(5'h04, 32'hFFFF_FFFE);
    idle();
    wr_reg(5'h04, 32'h10);
    rd_reg(5'h04); check("wr_beats_tick", last_rd, 32'h10);
    check("wr_no_irq", {31'd0, IRQ}, 32'd0);
    wr_reg(5'h04, 32'hFFFF_FFFE);
    idle();
    wr_reg(5'h08, 32'd3);
    idle();
    check("hwset_wins", {31'd0, IRQ}, 32'd1);
`endif

    // SYSTICK spacing and ignored writes
    rd_reg(5'h14); s0 = last_rd;
    wr_reg(5'h14, 32'h1234_5678);
    wr_reg(5'h0C, 32'hDEAD_BEEF);
    repeat (5) idle();
    rd_reg(5'h14); check("systick_delta", last_rd - s0, 32'd8);
    rd_reg(5'h0C); check("gap_reads_zero", last_rd, 32'd0);

    // prescale / per-cycle count from TL=0
    wr_reg(5'h08, 32'd0);
    wr_reg(5'h04, 32'd0);
    wr_reg(5'h08, 32'd1);
    repeat (12) idle();
    rd_reg(5'h04);
`ifdef TIMER_PRESCALE_EN
    check("count12", last_rd, 32'd3);
`else
    check("count12", last_rd, 32'd12);
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      a = BASE + {27'd0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 9) == 0) a = $urandom;
      case ($urandom_range(0, 3))
        0: d = $urandom;
        1: d = 32'hFFFF_FFFF;
        2: d = 32'hFFFF_FFFE - $urandom_range(0, 4);
        default: d = $urandom_range(0, 15);
      endcase
      kind = $urandom_range(0, 9);
      if (kind <= 3)      do_cycle(1'b1, 1'b0, a, d);
      else if (kind <= 7) do_cycle(1'b0, 1'b1, a, d);
      else if (kind == 8) do_cycle(1'b1, 1'b1, a, d);
      else                idle();
    end

    // asynchronous reset mid-count
    wr_reg(5'h04, 32'h1234);
    wr_reg(5'h08, 32'd7);
    idle();
    @(negedge clk);
    MemWrite = 0; MemRead = 1; Address = BASE + 32'h4;
    #2 reset = 1'b1;
    #1;
    check("async_tl", Read_data, 32'd0);
    check("async_irq", {31'd0, IRQ}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    rd_reg(5'h08); check("post_rst_tcon", last_rd, 32'd0);
    rd_reg(5'h00); check("post_rst_th", last_rd, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mmio_timer.md
Name: mmio_timer

Overview:
- Memory-mapped timer peripheral on the data side of the multi-cycle MIPS core.
- Consumes the core's load/store traffic (Address, Write_data, MemRead, MemWrite) in the peripheral address window and returns Read_data for the data-memory mux.
- Provides a reloadable interval timer with a sticky interrupt request, plus a free-running SysTick cycle counter.

Parameters:
- BASE_ADDR, 32'h4000_0000, byte address of the register window; must be 32-byte aligned.
- PRESCALE, 4, clock cycles per TL increment; used only when TIMER_PRESCALE_EN is defined; legal range 1..65535.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- Address  input  32  byte address from the core (ALU_out during a memory access).
- Write_data  input  32  store data (B register).
- MemRead  input  1  load strobe.
- MemWrite  input  1  store strobe; sampled on the rising clk edge.
- Read_data  output  32  load data; combinational.
- Sel  output  1  combinational; 1 when Address lies in the window, for the data-return mux.
- IRQ  output  1  interrupt request; equals TCON[2].

Behaviour:
- Window decode: Sel = (Address[31:5] == BASE_ADDR[31:5]). Word offset = Address[4:2]; Address[1:0] ignored.
- Register map (offsets from BASE_ADDR):
  - 0x00 TH: reload value, R/W.
  - 0x04 TL: counter, R/W.
  - 0x08 TCON: bits [2:0] R/W, upper bits read 0.
  - 0x14 SYSTICK: read-only.
  - 0x0C, 0x10, 0x18, 0x1C read 0; writes to them are ignored.
- TCON bits:
  - [0] EN: counter enable.
  - [1] IE: interrupt enable.
  - [2] ST: sticky status.
- Read path: Read_data is combinational (zero-latency), matching the core's same-cycle memory read.
  - Read_data = selected register when Sel && MemRead; otherwise 32'h0.
- Write path: a register is written at the clk edge when Sel && MemWrite.
- Reset:
  - TH = TL = SYSTICK = 0; TCON = 3'b000.
  - IRQ = 0; Read_data = 0 (no access in progress).
  - Prescaler count (when built) = 0.
- Counting: when EN = 1, one tick occurs per cycle (or per PRESCALE cycles; see Optional Feature). On each tick:
  - TL != 32'hFFFF_FFFF: TL <= TL + 1.
  - TL == 32'hFFFF_FFFF (overflow): TL <= TH. If IE = 1, ST <= 1 in the same edge.
  - TH == 32'hFFFF_FFFF therefore overflows on every tick (period 1); this is legal.
- EN = 0: TL holds; ST holds.
- SYSTICK: increments by 1 every cycle regardless of TCON, from reset. It wraps 32'hFFFF_FFFF -> 0 without any flag. Writes are ignored.
- ST is sticky: software clears it only by writing TCON with bit2 = 0. Writing bit2 = 1 sets it.
- Simultaneous events (same edge):
  - CPU write to TL and a tick: the CPU write wins; the tick and overflow are lost. Reload from TH is suppressed.
  - CPU write to TH and overflow: TL reloads from the old TH; the new TH takes effect on the next overflow.
  - CPU write to TCON clearing ST and an overflow setting ST (IE = 1): hardware set wins, ST = 1.
  - CPU write to TCON clearing EN on a tick edge: this tick still takes effect; counting stops afterwards.
- Reset mid-count asynchronously forces all state to reset values; no overflow is reported.
- MemRead and MemWrite both high is illegal from the core. If it occurs, the read returns the pre-write value and the write occurs at the edge.

Optional Feature:
- Macro: TIMER_PRESCALE_EN.
- Defined:
  - A 16-bit prescaler counts cycles while EN = 1. A tick is issued when the count reaches PRESCALE-1; the count then returns to 0.
  - The prescaler resets to 0 when EN is written 0, and on any write to TL.
  - SYSTICK is unaffected.
- Undefined: no prescaler logic; the tick is every cycle while EN = 1, and PRESCALE is unused.

Test Plan:
- Reset release -> all registers read 0, IRQ = 0, Sel = 0 for Address = 0x0000_0010.
- Write TH = 0xFFFF_FFFC, TL = 0xFFFF_FFFE, TCON = 3'b011 -> TL reads 0xFFFF_FFFF after 1 cycle, 0xFFFF_FFFC after 2 cycles, with IRQ = 1 from that edge. IRQ stays 1 until TCON is written with 3'b011; then IRQ = 0 next cycle.
- TCON = 3'b001 (IE = 0), TL = 0xFFFF_FFFF -> TL reloads from TH with IRQ remaining 0; TCON read = 0x1.
- Write TL = 0x10 on the exact cycle TL would overflow -> TL = 0x10 next cycle, no reload, IRQ unchanged. Also clear ST on an overflow edge with IE = 1 -> IRQ stays 1.
- SYSTICK read at two cycles N apart -> difference = N. Writes to 0x14 and to 0x0C are ignored; a read of 0x0C = 0. Assert reset mid-count -> TL = 0, IRQ = 0 immediately.
- With TIMER_PRESCALE_EN and PRESCALE = 4, TCON = 1, TL = 0 -> TL = 1 after 4 cycles and 3 after 12 cycles. Without the macro, the same stimulus gives TL = 12 after 12 cycles.
